ghost_map_writer: RTL and testbench
===================================

// Module: ghost_map_writer
// PURPOSE
//  Downstream of the ghost path controller. When either ghost's next tile differs from its current tile,
//  writes the move into the shared tile-map RAM: restores the tiles under both ghosts, saves the new
//  under-tiles, and writes the ghost codes. Pulses wrdone so the controller commits curr<=next.
//  Reports ghost/pacman collisions.
// PARAMETERS
//  X_W      6   tile x-coordinate width
//  Y_W      5   tile y-coordinate width
//  TILE_W   3   tile code width (codes in pacman_map_pkg)
// PORTS
//  CLOCK_50        in   1      system clock; single clock domain
//  reset           in   1      asynchronous, active-high reset
//  enable          in   1      1 = moves may start; 0 = stay in IDLE (an op in flight completes)
//  curr_ghost1_x/y in   X_W/Y_W  committed ghost1 tile
//  next_ghost1_x/y in   X_W/Y_W  requested ghost1 tile
//  curr_ghost2_x/y in   X_W/Y_W  committed ghost2 tile
//  next_ghost2_x/y in   X_W/Y_W  requested ghost2 tile
//  curr_pacman_x/y in   X_W/Y_W  pacman tile
//  map_req         out  1      map-port request; held from REQ through DONE
//  map_gnt         in   1      map-port grant from the arbiter
//  map_rdaddr_x/y  out  X_W/Y_W  map read address; sync RAM, data valid 1 cycle later
//  map_rddata      in   TILE_W   map read data
//  map_wr_en       out  1      map write strobe, 1 cycle per write
//  map_wraddr_x/y  out  X_W/Y_W  map write address
//  map_wrdata      out  TILE_W   map write data
//  wrdone          out  1      1-cycle pulse: map updated; controller commits next->curr
//  collision_type  out  2      bit0 = ghost1 on pacman, bit1 = ghost2 on pacman; held until next DONE
// BEHAVIOUR
//  Reset (async): state=IDLE; map_req, map_wr_en, wrdone, collision_type=0; all addresses and wrdata=0;
//   under1/under2 regs=TILE_EMPTY. The map init image already holds GHOST codes at (16,13) and (23,13).
//  FSM: IDLE -> REQ -> ERASE1 -> ERASE2 -> READ1 -> CAPT1 -> READ2 -> CAPT2 -> DONE -> SETTLE -> IDLE.
//   IDLE:   go to REQ when enable && (next1!=curr1 || next2!=curr2). Next/curr are sampled into
//           internal regs on this transition and used for the whole op.
//   REQ:    map_req=1; wait for map_gnt (no timeout).
//   ERASE1: write under1 to curr1.  ERASE2: write under2 to curr2. Erasing both first means no
//           GHOST code is ever captured as an under-tile.
//   READ1:  rdaddr=next1.
//   CAPT1:  under1<=f(map_rddata); write TILE_GHOST1 to next1.
//   READ2:  rdaddr=next2.
//   CAPT2:  under2<=f(map_rddata); write TILE_GHOST2 to next2.
//           If next2==next1, bypass the RAM: under2<=under1 and read data is ignored.
//   f(t):   TILE_PACMAN -> TILE_EMPTY; otherwise t.
//   DONE:   wrdone=1 for 1 cycle; collision_type<={next2==pac, next1==pac}; map_req drops after DONE.
//   SETTLE: 1 idle cycle so the controller's curr update is visible; prevents a re-trigger on stale curr.
//  Latency: gnt-to-wrdone = 7 cycles (ERASE1..DONE). Exactly 4 writes per op, including a ghost that
//   does not move (its tile is erased and rewritten with the same under-tile).
//  map_wr_en is asserted only in ERASE1, ERASE2, CAPT1 and CAPT2.
//  enable falling mid-op: the op completes. Reset mid-op: immediate abort to reset values; a partially
//   written map is acceptable because the system reset reloads the map.
//  Coordinates are not range-checked; the controller never proposes walls or off-map tiles.
// STRUCTURE
//  pacman_map_pkg holds:
//   - tile typedef tile_t (TILE_W bits);
//   - codes TILE_EMPTY=0, TILE_WALL=1, TILE_PILL=2, TILE_POWER=3, TILE_PACMAN=4, TILE_GHOST1=5,
//     TILE_GHOST2=6;
//   - ghost reset coordinates;
//   - the FSM state enum.
//  Single module; no sub-module. The pos-compare and f() logic are inline combinational.
// TESTING
//  1 Ghost1 (16,13)->(16,12) over PILL, ghost2 idle; gnt same cycle -> writes EMPTY@(16,13),
//    EMPTY@(23,13), GHOST1@(16,12), GHOST2@(23,13); wrdone 7 cycles after gnt; under1=PILL.
//  2 Next move of ghost1 back to (16,13) -> PILL restored at (16,12), GHOST1@(16,13).
//  3 next1=next2=(20,13) over POWER -> under1=under2=POWER; last write is GHOST2@(20,13).
//  4 Pacman at (16,12), ghost1 moves there -> collision_type=2'b01 from DONE; under1=EMPTY.
//  5 gnt held low 10 cycles -> map_req high, no writes, no wrdone. Then gnt=1 -> normal sequence.
//  6 Async reset asserted in CAPT1 -> outputs 0 with no clock edge; enable=0 afterwards -> stays IDLE.

Source files
------------

// File: rtl/pacman_map_pkg.sv
// Shared tile-map definitions: tile codes, ghost start tiles and the
// ghost map writer state encoding.
package pacman_map_pkg;

  localparam int TILE_W = 3;

  typedef logic [TILE_W-1:0] tile_t;

  localparam tile_t TILE_EMPTY  = 3'd0;
  localparam tile_t TILE_WALL   = 3'd1;
  localparam tile_t TILE_PILL   = 3'd2;
  localparam tile_t TILE_POWER  = 3'd3;
  localparam tile_t TILE_PACMAN = 3'd4;
  localparam tile_t TILE_GHOST1 = 3'd5;
  localparam tile_t TILE_GHOST2 = 3'd6;

  // Ghost start tiles; the map init image holds the ghost codes here.
  localparam int G1_RST_X = 16;
  localparam int G1_RST_Y = 13;
  localparam int G2_RST_X = 23;
  localparam int G2_RST_Y = 13;

  typedef enum logic [3:0] {
    S_IDLE,
    S_REQ,
    S_ERASE1,
    S_ERASE2,
    S_READ1,
    S_CAPT1,
    S_READ2,
    S_CAPT2,
    S_DONE,
    S_SETTLE
  } state_e;

endpackage

// File: rtl/ghost_map_writer_if.sv
// Tile-map RAM port: request/grant to the arbiter plus a synchronous read
// port (data one cycle after the address) and a single-cycle write strobe.
interface ghost_map_writer_if #(
  parameter int X_W    = 6,
  parameter int Y_W    = 5,
  parameter int TILE_W = 3
);
  logic              map_req;
  logic              map_gnt;
  logic [X_W-1:0]    map_rdaddr_x;
  logic [Y_W-1:0]    map_rdaddr_y;
  logic [TILE_W-1:0] map_rddata;
  logic              map_wr_en;
  logic [X_W-1:0]    map_wraddr_x;
  logic [Y_W-1:0]    map_wraddr_y;
  logic [TILE_W-1:0] map_wrdata;

  modport master (
    output map_req, map_rdaddr_x, map_rdaddr_y,
    output map_wr_en, map_wraddr_x, map_wraddr_y, map_wrdata,
    input  map_gnt, map_rddata
  );

  modport slave (
    input  map_req, map_rdaddr_x, map_rdaddr_y,
    input  map_wr_en, map_wraddr_x, map_wraddr_y, map_wrdata,
    output map_gnt, map_rddata
  );
endinterface

// File: rtl/ghost_map_writer.sv
// Ghost map writer: applies one ghost move (both ghosts) to the shared
// tile map as erase/erase/read/write/read/write, then pulses wrdone so the
// path controller commits its next tiles. Reports ghost/pacman overlap.
module ghost_map_writer
  import pacman_map_pkg::*;
#(
  parameter int X_W    = 6,
  parameter int Y_W    = 5,
  parameter int TILE_W = 3
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                enable,
  input  logic [X_W-1:0]      curr_ghost1_x,
  input  logic [Y_W-1:0]      curr_ghost1_y,
  input  logic [X_W-1:0]      next_ghost1_x,
  input  logic [Y_W-1:0]      next_ghost1_y,
  input  logic [X_W-1:0]      curr_ghost2_x,
  input  logic [Y_W-1:0]      curr_ghost2_y,
  input  logic [X_W-1:0]      next_ghost2_x,
  input  logic [Y_W-1:0]      next_ghost2_y,
  input  logic [X_W-1:0]      curr_pacman_x,
  input  logic [Y_W-1:0]      curr_pacman_y,
  ghost_map_writer_if.master  map,
  output logic                wrdone,
  output logic [1:0]          collision_type
);

  localparam logic [TILE_W-1:0] T_EMPTY  = TILE_W'(TILE_EMPTY);
  localparam logic [TILE_W-1:0] T_PACMAN = TILE_W'(TILE_PACMAN);
  localparam logic [TILE_W-1:0] T_GHOST1 = TILE_W'(TILE_GHOST1);
  localparam logic [TILE_W-1:0] T_GHOST2 = TILE_W'(TILE_GHOST2);

  state_e state_q, state_d;
  logic [X_W-1:0] c1x_q, c1x_d, n1x_q, n1x_d, c2x_q, c2x_d, n2x_q, n2x_d;
  logic [Y_W-1:0] c1y_q, c1y_d, n1y_q, n1y_d, c2y_q, c2y_d, n2y_q, n2y_d;
  logic [TILE_W-1:0] under1_q, under1_d, under2_q, under2_d;
  logic [1:0] coll_q, coll_d;

  logic move_req, same_next;
  logic [1:0] coll_now;
  logic [TILE_W-1:0] rd_under;

  // Move detection, shared-target detection, pacman overlap, under-tile filter
  always_comb begin
    move_req  = (next_ghost1_x != curr_ghost1_x) || (next_ghost1_y != curr_ghost1_y) ||
                (next_ghost2_x != curr_ghost2_x) || (next_ghost2_y != curr_ghost2_y);
    same_next = (n1x_q == n2x_q) && (n1y_q == n2y_q);
    coll_now  = {(n2x_q == curr_pacman_x) && (n2y_q == curr_pacman_y),
                 (n1x_q == curr_pacman_x) && (n1y_q == curr_pacman_y)};
    // Pacman is transient; leaving it as an under-tile would redraw a stale pacman.
    rd_under  = (map.map_rddata == T_PACMAN) ? T_EMPTY : map.map_rddata;
  end

  // State and operation registers; reset aborts any op in flight
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      c1x_q    <= X_W'(G1_RST_X);
      c1y_q    <= Y_W'(G1_RST_Y);
      n1x_q    <= X_W'(G1_RST_X);
      n1y_q    <= Y_W'(G1_RST_Y);
      c2x_q    <= X_W'(G2_RST_X);
      c2y_q    <= Y_W'(G2_RST_Y);
      n2x_q    <= X_W'(G2_RST_X);
      n2y_q    <= Y_W'(G2_RST_Y);
      under1_q <= T_EMPTY;
      under2_q <= T_EMPTY;
      coll_q   <= 2'b00;
    end else begin
      state_q  <= state_d;
      c1x_q    <= c1x_d;
      c1y_q    <= c1y_d;
      n1x_q    <= n1x_d;
      n1y_q    <= n1y_d;
      c2x_q    <= c2x_d;
      c2y_q    <= c2y_d;
      n2x_q    <= n2x_d;
      n2y_q    <= n2y_d;
      under1_q <= under1_d;
      under2_q <= under2_d;
      coll_q   <= coll_d;
    end
  end

  // Next-state and register update logic
  always_comb begin
    state_d  = state_q;
    c1x_d    = c1x_q;
    c1y_d    = c1y_q;
    n1x_d    = n1x_q;
    n1y_d    = n1y_q;
    c2x_d    = c2x_q;
    c2y_d    = c2y_q;
    n2x_d    = n2x_q;
    n2y_d    = n2y_q;
    under1_d = under1_q;
    under2_d = under2_q;
    coll_d   = coll_q;
    case (state_q)
      S_IDLE: begin
        if (enable && move_req) begin
          state_d = S_REQ;
          c1x_d = curr_ghost1_x;  c1y_d = curr_ghost1_y;
          n1x_d = next_ghost1_x;  n1y_d = next_ghost1_y;
          c2x_d = curr_ghost2_x;  c2y_d = curr_ghost2_y;
          n2x_d = next_ghost2_x;  n2y_d = next_ghost2_y;
        end
      end
      S_REQ:    if (map.map_gnt) state_d = S_ERASE1;
      S_ERASE1: state_d = S_ERASE2;
      S_ERASE2: state_d = S_READ1;
      S_READ1:  state_d = S_CAPT1;
      S_CAPT1: begin
        under1_d = rd_under;
        state_d  = S_READ2;
      end
      S_READ2:  state_d = S_CAPT2;
      S_CAPT2: begin
        // Shared target: the RAM now holds GHOST1 there, so reuse ghost1's under-tile.
        under2_d = same_next ? under1_q : rd_under;
        state_d  = S_DONE;
      end
      S_DONE: begin
        coll_d  = coll_now;
        state_d = S_SETTLE;
      end
      S_SETTLE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Map port and status outputs decoded from the current state
  always_comb begin
    map.map_req      = 1'b0;
    map.map_wr_en    = 1'b0;
    map.map_wraddr_x = '0;
    map.map_wraddr_y = '0;
    map.map_wrdata   = '0;
    map.map_rdaddr_x = '0;
    map.map_rdaddr_y = '0;
    wrdone           = 1'b0;
    collision_type   = coll_q;
    case (state_q)
      S_REQ: map.map_req = 1'b1;
      S_ERASE1: begin
        map.map_req = 1'b1;  map.map_wr_en = 1'b1;
        map.map_wraddr_x = c1x_q;  map.map_wraddr_y = c1y_q;  map.map_wrdata = under1_q;
      end
      S_ERASE2: begin
        map.map_req = 1'b1;  map.map_wr_en = 1'b1;
        map.map_wraddr_x = c2x_q;  map.map_wraddr_y = c2y_q;  map.map_wrdata = under2_q;
      end
      S_READ1: begin
        map.map_req = 1'b1;
        map.map_rdaddr_x = n1x_q;  map.map_rdaddr_y = n1y_q;
      end
      S_CAPT1: begin
        map.map_req = 1'b1;  map.map_wr_en = 1'b1;
        map.map_wraddr_x = n1x_q;  map.map_wraddr_y = n1y_q;  map.map_wrdata = T_GHOST1;
      end
      S_READ2: begin
        map.map_req = 1'b1;
        map.map_rdaddr_x = n2x_q;  map.map_rdaddr_y = n2y_q;
      end
      S_CAPT2: begin
        map.map_req = 1'b1;  map.map_wr_en = 1'b1;
        map.map_wraddr_x = n2x_q;  map.map_wraddr_y = n2y_q;  map.map_wrdata = T_GHOST2;
      end
      S_DONE: begin
        map.map_req    = 1'b1;
        wrdone         = 1'b1;
        collision_type = coll_now;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ghost_map_writer.sv
// Directed bench for ghost_map_writer: a tile-map RAM model, the bench acting
// as path controller (commits curr<=next on wrdone) and as the map arbiter.
module tb_ghost_map_writer;
  import pacman_map_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic [5:0] c1x = 6'd16, n1x = 6'd16, c2x = 6'd23, n2x = 6'd23, pcx = 6'd0;
  logic [4:0] c1y = 5'd13, n1y = 5'd13, c2y = 5'd13, n2y = 5'd13, pcy = 5'd0;
  logic wrdone;
  logic [1:0] collision_type;

  int n_cmp = 0;
  int n_fail = 0;

  ghost_map_writer_if #(.X_W(6), .Y_W(5), .TILE_W(3)) mif ();

  ghost_map_writer #(.X_W(6), .Y_W(5), .TILE_W(3)) dut (
    .CLOCK_50(clk), .reset(rst), .enable(enable),
    .curr_ghost1_x(c1x), .curr_ghost1_y(c1y), .next_ghost1_x(n1x), .next_ghost1_y(n1y),
    .curr_ghost2_x(c2x), .curr_ghost2_y(c2y), .next_ghost2_x(n2x), .next_ghost2_y(n2y),
    .curr_pacman_x(pcx), .curr_pacman_y(pcy),
    .map(mif.master), .wrdone(wrdone), .collision_type(collision_type)
  );

  always #5 clk = ~clk;

  // Tile-map RAM model with a backdoor port and a log of DUT writes {x,y,data}
  logic [2:0] ram [0:63][0:31];
  logic bd_en = 1'b0;
  logic [5:0] bd_x = '0;
  logic [4:0] bd_y = '0;
  logic [2:0] bd_d = '0;
  logic [13:0] wlog [$];
  logic [2:0] rd_q;
  initial mif.map_gnt = 1'b0;
  assign mif.map_rddata = rd_q;

  always @(posedge clk) begin
    rd_q <= ram[mif.map_rdaddr_x][mif.map_rdaddr_y];
    if (bd_en) ram[bd_x][bd_y] <= bd_d;
    else if (mif.map_wr_en) begin
      ram[mif.map_wraddr_x][mif.map_wraddr_y] <= mif.map_wrdata;
      wlog.push_back({mif.map_wraddr_x, mif.map_wraddr_y, mif.map_wrdata});
    end
  end

  logic [13:0] exp_w [4];

  function automatic logic [13:0] wr(input int x, input int y, input tile_t d);
    return {6'(x), 5'(y), d};
  endfunction

  function automatic logic [29:0] outs();
    return {mif.map_req, mif.map_wr_en, wrdone, collision_type, mif.map_wraddr_x,
            mif.map_wraddr_y, mif.map_wrdata, mif.map_rdaddr_x, mif.map_rdaddr_y};
  endfunction

  task automatic bd_write(input int x, input int y, input tile_t d);
    bd_x = 6'(x); bd_y = 5'(y); bd_d = d; bd_en = 1'b1;
    @(posedge clk); #1;
    bd_en = 1'b0;
  endtask

  task automatic test_reset();
    bd_write(16, 13, TILE_GHOST1);
    bd_write(23, 13, TILE_GHOST2);
    bd_write(16, 12, TILE_PILL);
    bd_write(20, 13, TILE_POWER);
    @(negedge clk);
    n_cmp++;
    if (outs() !== 30'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", outs());
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (mif.map_req !== 1'b0 || wlog.size() != 0) begin
      n_fail++;
      $display("FAIL idle_no_move: req=%b writes=%0d expected req=0 writes=0", mif.map_req, wlog.size());
    end
  endtask

  // One full move: hold = cycles gnt stays low after map_req rises.
  task automatic do_move(input string nm, input int hold, input logic [1:0] ecoll);
    int req_cyc, gnt_cyc, done_cyc, wbase;
    bit hold_bad;
    req_cyc = -1; gnt_cyc = -1; done_cyc = -1; hold_bad = 0;
    wbase = wlog.size();
    mif.map_gnt = (hold == 0);
    enable = 1'b1;
    for (int cyc = 0; cyc < 60 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      if (req_cyc < 0 && mif.map_req === 1'b1) begin
        req_cyc = cyc;
        if (hold == 0) gnt_cyc = cyc;
      end
      if (req_cyc >= 0 && gnt_cyc < 0) begin
        if (mif.map_req !== 1'b1 || mif.map_wr_en !== 1'b0 || wrdone !== 1'b0 || wlog.size() != wbase)
          hold_bad = 1;
        if (cyc - req_cyc == hold) begin
          mif.map_gnt = 1'b1;
          gnt_cyc = cyc;
        end
      end
      if (wrdone === 1'b1) begin
        done_cyc = cyc;
        n_cmp++;
        if (collision_type !== ecoll) begin
          n_fail++;
          $display("FAIL %s_collision_in_done: got %b expected %b", nm, collision_type, ecoll);
        end
      end
    end
    if (hold > 0) begin
      n_cmp++;
      if (hold_bad) begin
        n_fail++;
        $display("FAIL %s_stall: activity while waiting for gnt, expected req=1 and no writes/wrdone", nm);
      end
    end
    n_cmp++;
    if (done_cyc < 0) begin
      n_fail++;
      $display("FAIL %s_timeout: wrdone not seen, expected within 60 cycles", nm);
    end else begin
      n_cmp++;
      if (done_cyc - gnt_cyc != 7) begin
        n_fail++;
        $display("FAIL %s_latency: gnt-to-wrdone %0d expected 7", nm, done_cyc - gnt_cyc);
      end
    end
    n_cmp++;
    if (wlog.size() - wbase != 4) begin
      n_fail++;
      $display("FAIL %s_write_count: got %0d expected 4", nm, wlog.size() - wbase);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (wlog[wbase+i] !== exp_w[i]) begin
          n_fail++;
          $display("FAIL %s_write%0d: got x=%0d y=%0d d=%0d expected x=%0d y=%0d d=%0d", nm, i,
                   wlog[wbase+i][13:8], wlog[wbase+i][7:3], wlog[wbase+i][2:0],
                   exp_w[i][13:8], exp_w[i][7:3], exp_w[i][2:0]);
        end
      end
    end
    // Controller role: commit next->curr right after DONE.
    @(posedge clk); #1;
    c1x = n1x; c1y = n1y; c2x = n2x; c2y = n2y;
    mif.map_gnt = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (mif.map_req !== 1'b0 || wrdone !== 1'b0 || collision_type !== ecoll) begin
      n_fail++;
      $display("FAIL %s_settle: req=%b wrdone=%b coll=%b expected req=0 wrdone=0 coll=%b",
               nm, mif.map_req, wrdone, collision_type, ecoll);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (mif.map_req !== 1'b0 || wlog.size() - wbase != 4) begin
      n_fail++;
      $display("FAIL %s_no_retrigger: req=%b writes=%0d expected req=0 writes=4",
               nm, mif.map_req, wlog.size() - wbase);
    end
  endtask

  task automatic test_ghost1_step();
    n1x = 6'd16; n1y = 5'd12;
    exp_w[0] = wr(16, 13, TILE_EMPTY);
    exp_w[1] = wr(23, 13, TILE_EMPTY);
    exp_w[2] = wr(16, 12, TILE_GHOST1);
    exp_w[3] = wr(23, 13, TILE_GHOST2);
    do_move("step", 0, 2'b00);
  endtask

  task automatic test_ghost1_back();
    n1x = 6'd16; n1y = 5'd13;
    exp_w[0] = wr(16, 12, TILE_PILL);
    exp_w[1] = wr(23, 13, TILE_EMPTY);
    exp_w[2] = wr(16, 13, TILE_GHOST1);
    exp_w[3] = wr(23, 13, TILE_GHOST2);
    do_move("back", 0, 2'b00);
  endtask

  task automatic test_shared_target();
    n1x = 6'd20; n1y = 5'd13; n2x = 6'd20; n2y = 5'd13;
    exp_w[0] = wr(16, 13, TILE_EMPTY);
    exp_w[1] = wr(23, 13, TILE_EMPTY);
    exp_w[2] = wr(20, 13, TILE_GHOST1);
    exp_w[3] = wr(20, 13, TILE_GHOST2);
    do_move("shared", 0, 2'b00);
  endtask

  // Ghost2 stays on (20,13); both erases restore POWER captured by the shared move.
  task automatic test_collision();
    bd_write(16, 12, TILE_PACMAN);
    pcx = 6'd16; pcy = 5'd12;
    n1x = 6'd16; n1y = 5'd12;
    exp_w[0] = wr(20, 13, TILE_POWER);
    exp_w[1] = wr(20, 13, TILE_POWER);
    exp_w[2] = wr(16, 12, TILE_GHOST1);
    exp_w[3] = wr(20, 13, TILE_GHOST2);
    do_move("collide", 0, 2'b01);
  endtask

  // Ghost1 leaves the pacman tile: its under-tile must come back as EMPTY.
  task automatic test_gnt_stall();
    bd_write(16, 11, TILE_PILL);
    n_cmp++;
    if (collision_type !== 2'b01) begin
      n_fail++;
      $display("FAIL collision_held: got %b expected 01", collision_type);
    end
    n1x = 6'd16; n1y = 5'd11;
    exp_w[0] = wr(16, 12, TILE_EMPTY);
    exp_w[1] = wr(20, 13, TILE_POWER);
    exp_w[2] = wr(16, 11, TILE_GHOST1);
    exp_w[3] = wr(20, 13, TILE_GHOST2);
    do_move("stall", 10, 2'b00);
  endtask

  task automatic test_reset_mid_op();
    int wbase;
    bit found;
    found = 0;
    n1x = 6'd16; n1y = 5'd10;
    mif.map_gnt = 1'b1;
    enable = 1'b1;
    for (int cyc = 0; cyc < 30 && !found; cyc++) begin
      @(negedge clk);
      if (mif.map_wr_en === 1'b1 && mif.map_wrdata === TILE_GHOST1) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_fail++;
      $display("FAIL midreset_reach_capt1: CAPT1 write not seen, expected within 30 cycles");
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (outs() !== 30'd0) begin
      n_fail++;
      $display("FAIL midreset_async: got %h expected 0 before any clock edge", outs());
    end
    enable = 1'b0;
    mif.map_gnt = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    wbase = wlog.size();
    repeat (10) @(negedge clk);
    n_cmp++;
    if (mif.map_req !== 1'b0 || wrdone !== 1'b0 || wlog.size() != wbase) begin
      n_fail++;
      $display("FAIL midreset_idle: req=%b wrdone=%b writes=%0d expected 0 0 0",
               mif.map_req, wrdone, wlog.size() - wbase);
    end
  endtask

  initial begin
    test_reset();
    test_ghost1_step();
    test_ghost1_back();
    test_shared_target();
    test_collision();
    test_gnt_stall();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
